// File: rtl/spram_req_ctrl_pkg.sv
// rtl/spram_req_ctrl_pkg.sv - shared helpers for the single-port RAM request controller
//
// Purpose: read-latency helper shared by the controller and anything that
// needs to know how many cycles a RAM read takes.
// Ports: none (package).
package spram_pkg;

  // RAM read latency: a registered q adds one cycle on top of the address cycle.
  function automatic int read_lat(input logic [7:0] regout);
    return (regout == "Y") ? 2 : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// rtl/sync_fifo_sa.sv - show-ahead synchronous FIFO
//
// Purpose: small FIFO whose head entry is visible on head whenever !empty.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write an entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   empty, full       status
//   count             number of stored entries
//   head              current head entry (stale when empty)
module sync_fifo_sa #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  // Derived width of count; leave at its default.
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap for free.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observed after it was pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/spram_req_ctrl.sv
// rtl/spram_req_ctrl.sv - initiator-side request controller for a byte-enabled single-port RAM
//
// Purpose: accepts read/write requests, drives the RAM port from registers,
// hides the RAM read latency and returns read data through a credit-limited
// response FIFO so that response backpressure never loses data.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we/req_addr/req_data/req_be request payload (be ignored for reads)
//   rsp_valid/rsp_ready/rsp_data    read response handshake and data
//   mem_we/mem_addr/mem_data/mem_be registered RAM port
//   mem_q                           RAM read data
module spram_req_ctrl
  import spram_pkg::*;
#(
  parameter int         DWIDTH    = 128,
  parameter int         AWIDTH    = 4,
  parameter logic [7:0] REGOUT    = "Y",
  parameter int         BEWIDTH   = DWIDTH / 8,
  parameter int         RSP_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [AWIDTH-1:0]  req_addr,
  input  logic [DWIDTH-1:0]  req_data,
  input  logic [BEWIDTH-1:0] req_be,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DWIDTH-1:0]  rsp_data,
  output logic               mem_we,
  output logic [AWIDTH-1:0]  mem_addr,
  output logic [DWIDTH-1:0]  mem_data,
  output logic [BEWIDTH-1:0] mem_be,
  input  logic [DWIDTH-1:0]  mem_q
);

  localparam int            LAT     = read_lat(REGOUT);
  localparam int            CW      = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  typedef struct packed {
    logic               we;
    logic [AWIDTH-1:0]  addr;
    logic [DWIDTH-1:0]  data;
    logic [BEWIDTH-1:0] be;
  } req_t;

  if ((DWIDTH % 8) != 0) begin : g_chk_dwidth
    $error("spram_req_ctrl: DWIDTH must be a multiple of 8");
  end
  if (BEWIDTH != DWIDTH / 8) begin : g_chk_bewidth
    $error("spram_req_ctrl: BEWIDTH must equal DWIDTH/8");
  end
  if ((RSP_DEPTH < 2) || ((RSP_DEPTH & (RSP_DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("spram_req_ctrl: RSP_DEPTH must be a power of 2 and >= 2");
  end

  req_t              issue_q, issue_d;
  logic [LAT-1:0]    tag_q, tag_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic              ready_q, ready_d;
  logic [DWIDTH-1:0] last_head_q, last_head_d;

  logic              req_hs, rd_acc;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_count;
  logic [DWIDTH-1:0] fifo_head;

  always_comb begin
    req_hs    = req_valid && ready_q;
    rd_acc    = req_hs && !req_we;
    fifo_push = tag_q[LAT-1];
    fifo_pop  = !fifo_empty && rsp_ready;

    // Strobes drop when idle; address/data hold their last issued value.
    issue_d    = issue_q;
    issue_d.we = 1'b0;
    issue_d.be = '0;
    if (req_hs) begin
      issue_d.we   = req_we;
      issue_d.addr = req_addr;
      issue_d.data = req_data;
      issue_d.be   = req_we ? req_be : '0;
    end

    // One valid tag per read, shifted LAT times so it exits exactly when mem_q is valid.
    tag_d    = '0;
    tag_d[0] = rd_acc;
    for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];

    // Credits cover reads in the pipe plus reads in the FIFO, so a push can never
    // find the FIFO full.
    outst_d = outst_q + CW'(rd_acc) - CW'(fifo_pop);
    // Registered so that req_ready is low throughout reset and never depends on req_valid.
    ready_d = (outst_d < DEPTH_C);

    last_head_d = fifo_empty ? last_head_q : fifo_head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q     <= '0;
      tag_q       <= '0;
      outst_q     <= '0;
      ready_q     <= 1'b0;
      last_head_q <= '0;
    end else begin
      issue_q     <= issue_d;
      tag_q       <= tag_d;
      outst_q     <= outst_d;
      ready_q     <= ready_d;
      last_head_q <= last_head_d;
    end
  end

  sync_fifo_sa #(
    .WIDTH (DWIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (mem_q),
    .pop       (fifo_pop),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign req_ready = ready_q;
  assign rsp_valid = !fifo_empty;
  // Hold the last shown head while empty so rsp_data does not wander.
  assign rsp_data  = fifo_empty ? last_head_q : fifo_head;
  assign mem_we    = issue_q.we;
  assign mem_addr  = issue_q.addr;
  assign mem_data  = issue_q.data;
  assign mem_be    = issue_q.be;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= outst_q);

endmodule
